// File: rtl/ren_chain_scheduler.sv
// Round-robin scheduler sharing one registered ren pass-through chain among NREQ requesters.
// A shadow shift register tracks each in-flight pulse and its owner, and is checked against the chain taps.
module ren_chain_scheduler #(
  parameter int NREQ         = 4,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int TAG_W        = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  io_req_valid,
  output logic [NREQ-1:0]  io_req_grant,
  input  logic             io_flush,
  output logic             io_chain_ren,
  input  logic [DEPTH-1:0] io_chain_tap,
  output logic             io_resp_valid,
  output logic [TAG_W-1:0] io_resp_id,
  output logic             io_busy,
  output logic             io_err
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int FLC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t             state;
  logic [TAG_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   inflight;
  logic [FLC_W-1:0]   flush_cnt;
  logic [DEPTH-1:0]   shadow_v;
  logic [TAG_W-1:0]   shadow_tag [DEPTH];

  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;
  logic               retire;

  assign retire  = shadow_v[DEPTH-1];
  assign io_busy = (state != ST_IDLE);

  // Scan requesters starting at rr_ptr, wrapping; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand         = 0;
    io_req_grant = '0;
    grant_any    = 1'b0;
    grant_idx    = '0;
    if (state == ST_RUN && !io_flush && inflight < CNT_W'(MAX_INFLIGHT)) begin
      for (int unsigned n = 0; n < NREQ; n++) begin
        cand = (32'(rr_ptr) + n) % NREQ;
        if (!grant_any && io_req_valid[TAG_W'(cand)]) begin
          grant_any                    = 1'b1;
          grant_idx                    = TAG_W'(cand);
          io_req_grant[TAG_W'(cand)]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      inflight      <= '0;
      flush_cnt     <= '0;
      shadow_v      <= '0;
      io_chain_ren  <= 1'b0;
      io_resp_valid <= 1'b0;
      io_resp_id    <= '0;
      io_err        <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) shadow_tag[k] <= '0;
    end else begin
      if (state == ST_RUN && io_chain_tap != shadow_v) io_err <= 1'b1;

      if (io_flush) begin
        // In-chain pulses drain unreported; only rr_ptr and io_err survive.
        state         <= ST_FLUSH;
        flush_cnt     <= FLC_W'(DEPTH - 1);
        shadow_v      <= '0;
        inflight      <= '0;
        io_chain_ren  <= 1'b0;
        io_resp_valid <= 1'b0;
        io_resp_id    <= '0;
      end else begin
        for (int unsigned k = DEPTH - 1; k > 0; k--) begin
          shadow_v[k]   <= shadow_v[k-1];
          shadow_tag[k] <= shadow_tag[k-1];
        end
        shadow_v[0]   <= grant_any;
        shadow_tag[0] <= grant_any ? grant_idx : '0;
        io_chain_ren  <= grant_any;
        io_resp_valid <= retire;
        io_resp_id    <= retire ? shadow_tag[DEPTH-1] : '0;

        if (grant_any && !retire)      inflight <= inflight + 1'b1;
        else if (!grant_any && retire) inflight <= inflight - 1'b1;

        if (grant_any)
          rr_ptr <= (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

        case (state)
          ST_IDLE:  if (|io_req_valid) state <= ST_RUN;
          ST_RUN:   if (inflight == '0 && !(|io_req_valid)) state <= ST_IDLE;
          ST_FLUSH: begin
            if (flush_cnt == '0) state <= ST_IDLE;
            else                 flush_cnt <= flush_cnt - 1'b1;
          end
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ren_chain_scheduler.sv
// Bench for ren_chain_scheduler: directed scenarios plus random traffic against a pulse-list model.
module tb_ren_chain_scheduler;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int MAXI  = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic             flush;
  logic             ren;
  logic [DEPTH-1:0] tap;
  logic             resp_v;
  logic [TAG_W-1:0] resp_id;
  logic             busy;
  logic             err;

  ren_chain_scheduler #(
    .NREQ(NREQ), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io_req_valid(req), .io_req_grant(grant),
    .io_flush(flush), .io_chain_ren(ren), .io_chain_tap(tap),
    .io_resp_valid(resp_v), .io_resp_id(resp_id), .io_busy(busy), .io_err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=idle 1=run 2=flush; in-flight pulses as (owner, age) lists.
  int m_mode, m_left, m_ptr;
  int q_id[$];
  int q_age[$];
  bit e_ren, e_rv, e_err;
  int e_rid;
  logic [NREQ-1:0] pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DEPTH-1:0] occ();
    logic [DEPTH-1:0] o;
    o = '0;
    foreach (q_age[j]) if (q_age[j] < DEPTH) o[q_age[j]] = 1'b1;
    return o;
  endfunction

  function automatic int pick();
    logic [NREQ-1:0] r;
    r = req;
    if (m_mode != 1 || flush || q_id.size() >= MAXI) return -1;
    for (int n = 0; n < NREQ; n++) begin
      int c;
      c = (m_ptr + n) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_ptr = 0;
    q_id.delete(); q_age.delete();
    e_ren = 0; e_rv = 0; e_err = 0; e_rid = 0;
    pend = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_ren"},   32'(ren), 0);
    chk({tag, "_rv"},    32'(resp_v), 0);
    chk({tag, "_rid"},   32'(resp_id), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  // One clock: drive at negedge, check just after, then advance the model at posedge.
  task automatic step(input logic [NREQ-1:0] new_req, input logic fl, input logic [DEPTH-1:0] inj);
    logic [NREQ-1:0]  eg, req_s;
    logic [DEPTH-1:0] tap_s, occ_s;
    int g, n_before;
    @(negedge clk);
    pend  = pend | new_req;
    req   = pend;
    flush = fl;
    occ_s = occ();
    tap   = occ_s ^ inj;
    #1;
    g  = pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("ren",   32'(ren), 32'(e_ren));
    chk("resp_v", 32'(resp_v), 32'(e_rv));
    if (e_rv) chk("resp_id", 32'(resp_id), 32'(e_rid));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("err",  32'(err), 32'(e_err));
    req_s = req; tap_s = tap; n_before = q_id.size();
    @(posedge clk);
    if (m_mode == 1 && tap_s != occ_s) e_err = 1;
    if (fl) begin
      q_id.delete(); q_age.delete();
      e_ren = 0; e_rv = 0;
      m_mode = 2; m_left = DEPTH;
    end else begin
      e_rv = 0;
      foreach (q_age[j]) q_age[j]++;
      if (q_age.size() > 0 && q_age[0] == DEPTH) begin
        e_rv  = 1;
        e_rid = q_id.pop_front();
        void'(q_age.pop_front());
      end
      e_ren = (g >= 0);
      if (g >= 0) begin
        q_id.push_back(g);
        q_age.push_back(0);
        m_ptr   = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end
      case (m_mode)
        0: if (req_s != '0) m_mode = 1;
        1: if (n_before == 0 && req_s == '0) m_mode = 0;
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; flush = 1'b0; tap = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single request from requester 0
    step(4'b0001, 1'b0, '0);
    idle_steps(9);

    // All requesters held: round-robin then inflight stall
    for (int i = 0; i < 14; i++) step(4'b1111, 1'b0, '0);
    idle_steps(10);

    // Flush with 3 in flight and a new request the same cycle
    step(4'b0111, 1'b0, '0);
    idle_steps(3);
    step(4'b0100, 1'b1, '0);
    idle_steps(12);

    // Random traffic: dense, then sparse, with occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic [NREQ-1:0] nr;
      nr = NREQ'($urandom);
      if (i >= 200 && ($urandom % 4) != 0) nr = '0;
      step(nr, ($urandom % 40) == 0, '0);
    end
    idle_steps(12);

    // Tap mismatch in RUN is sticky across flush
    step(4'b0010, 1'b0, '0);
    step('0, 1'b0, 4'b0100);
    idle_steps(2);
    step('0, 1'b1, '0);
    idle_steps(6);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, '0);
    #3;
    reset_n = 1'b0;
    req     = '0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(4'b1110, 1'b0, '0);
    step(4'b0001, 1'b0, '0);
    idle_steps(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
